// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: core redirect, instruction-memory request/response, decode-side instruction channel.
// master = fetch unit, slave = the surrounding core/memory environment.
interface fetch_unit_if #(parameter int size = 32);
    logic            redirect_valid;
    logic [size-1:0] redirect_pc;
    logic            imem_req_valid;
    logic [size-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [size-1:0] imem_resp_data;
    logic            inst_valid;
    logic [size-1:0] inst_data;
    logic [size-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem reads, buffers {pc, word} in a 2-entry FIFO.
// Latency: request accepted in N, response in N+k, instruction valid to decode in N+k+1.
// Backpressure: requests are credit-limited so FIFO plus in-flight never exceeds 2; redirect flushes.
module fetch_unit #(
    parameter int              size     = 32,
    parameter logic [size-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    logic [size-1:0] fetch_pc;
    logic [1:0]      outstanding;
    logic [1:0]      drop_cnt;
    logic [1:0]      fifo_cnt;

    // PCs of in-flight requests, consumed in response order
    logic [size-1:0] pcq [2];
    logic            pcq_wr;
    logic            pcq_rd;

    logic [size-1:0] fifo_pc  [2];
    logic [size-1:0] fifo_dat [2];
    logic            fifo_wr;
    logic            fifo_rd;

    logic            inst_vld;
    logic            pop;
    logic            credit_ok;
    logic            req_vld;
    logic            accept;
    logic            resp;
    logic            discard;
    logic            push;
    logic [size-1:0] redirect_aligned;

    always_comb begin
        inst_vld         = (fifo_cnt != 2'd0) && !bus.redirect_valid;
        pop              = inst_vld && bus.inst_ready;
        credit_ok        = ({1'b0, fifo_cnt} + {1'b0, outstanding}) < 3'd2;
        // Gated by rst_n so the request line is quiet throughout reset
        req_vld          = rst_n && !bus.redirect_valid && (credit_ok || pop);
        accept           = req_vld && bus.imem_req_ready;
        resp             = bus.imem_resp_valid && (outstanding != 2'd0);
        discard          = resp && (bus.redirect_valid || (drop_cnt != 2'd0));
        push             = resp && !discard;
        redirect_aligned = bus.redirect_pc & ~size'(3);
    end

    assign bus.imem_req_valid = req_vld;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = inst_vld;
    assign bus.inst_data      = (fifo_cnt != 2'd0) ? fifo_dat[fifo_rd] : '0;
    assign bus.inst_pc        = (fifo_cnt != 2'd0) ? fifo_pc[fifo_rd]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            fifo_cnt    <= 2'd0;
            fifo_wr     <= 1'b0;
            fifo_rd     <= 1'b0;
            pcq_wr      <= 1'b0;
            pcq_rd      <= 1'b0;
        end else begin
            // Discarded responses still retire an in-flight request
            outstanding <= outstanding + 2'(accept) - 2'(resp);
            if (accept) pcq_wr <= ~pcq_wr;
            if (resp)   pcq_rd <= ~pcq_rd;

            if (bus.redirect_valid) begin
                fetch_pc <= redirect_aligned;
                drop_cnt <= outstanding - 2'(resp);
                fifo_cnt <= 2'd0;
                fifo_wr  <= 1'b0;
                fifo_rd  <= 1'b0;
            end else begin
                if (accept)  fetch_pc <= fetch_pc + size'(4);
                if (discard) drop_cnt <= drop_cnt - 2'd1;
                if (push)    fifo_wr  <= ~fifo_wr;
                if (pop)     fifo_rd  <= ~fifo_rd;
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                    2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

    // Payload storage needs no reset: every read is qualified by a count
    always_ff @(posedge clk) begin
        if (accept) pcq[pcq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[fifo_wr]  <= pcq[pcq_rd];
            fifo_dat[fifo_wr] <= bus.imem_resp_data;
        end
    end

endmodule
